// File: rtl/elite_disp_word_bcd.sv
// SPI frame assembler plus sequential double-dabble: 24-bit word -> six BCD digits.
// Optional leading-zero blank mask when ELITE_BCD_LEADING_BLANK_EN is defined.
module elite_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module elite_disp_word_bcd #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_VALUE      = 999999
) (
  input  logic       CLOCK_50,
  input  logic       Reset_7Seg_n,
  input  logic [7:0] Elite_7Seg_Disp_Word,
  input  logic       Elite_7Seg_Set_Flag,
  output logic [3:0] Bcd_Digit_0,
  output logic [3:0] Bcd_Digit_1,
  output logic [3:0] Bcd_Digit_2,
  output logic [3:0] Bcd_Digit_3,
  output logic [3:0] Bcd_Digit_4,
  output logic [3:0] Bcd_Digit_5,
  output logic       Bcd_Digits_Valid,
  output logic       Bcd_Busy,
  output logic       Bcd_Overflow,
  output logic [5:0] Bcd_Blank_Mask
);
  localparam logic [23:0] MAX_W = 24'(MAX_VALUE);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;
  state_t state, state_nxt;

  // only the two earlier bytes of a frame need to be remembered
  logic [15:0] sr;
  logic [1:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic [23:0] pend_word;
  logic        pend;
  logic [23:0] frame_word;
  logic        frame_done, take;

  assign frame_word = {sr, Elite_7Seg_Disp_Word};
  assign frame_done = Elite_7Seg_Set_Flag && (byte_idx == 2'd2);
  assign take       = (state == S_IDLE) && pend;

  always_ff @(posedge CLOCK_50 or negedge Reset_7Seg_n) begin
    if (!Reset_7Seg_n) begin
      sr        <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      pend_word <= '0;
      pend      <= 1'b0;
    end else begin
      if (Elite_7Seg_Set_Flag) begin
        sr      <= frame_word[15:0];
        gap_cnt <= '0;
        byte_idx <= frame_done ? 2'd0 : byte_idx + 2'd1;
      end else if (byte_idx != 2'd0) begin
        if (gap_cnt == TO_LAST) begin
          byte_idx <= 2'd0;
          gap_cnt  <= '0;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end
      // a frame finishing on the take edge must survive, so set beats clear
      if (frame_done) begin
        pend_word <= frame_word;
        pend      <= 1'b1;
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

  logic [23:0] bin;
  logic [27:0] bcd, bcd_adj;
  logic [51:0] shifted;
  logic [4:0]  bit_cnt;
  logic        ovf_latch;
  logic [5:0]  mask_nxt;

  for (genvar c = 0; c < 7; c++) begin : g_col
    elite_bcd_add3 u_add3 (.din(bcd[4*c +: 4]), .dout(bcd_adj[4*c +: 4]));
  end

  assign shifted = {bcd_adj, bin} << 1;

  always_ff @(posedge CLOCK_50 or negedge Reset_7Seg_n) begin
    if (!Reset_7Seg_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pend) state_nxt = S_CONV;
      S_CONV: if (bit_cnt == 5'd23) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ELITE_BCD_LEADING_BLANK_EN
  logic [5:0] mask_q;
  always_comb begin
    mask_nxt    = '0;
    mask_nxt[5] = (bcd[23:20] == 4'd0);
    for (int n = 4; n >= 1; n--)
      mask_nxt[n] = mask_nxt[n+1] && (bcd[4*n +: 4] == 4'd0);
  end
  assign Bcd_Blank_Mask = mask_q;
`else
  assign mask_nxt       = '0;
  assign Bcd_Blank_Mask = 6'b000000;
`endif

  always_ff @(posedge CLOCK_50 or negedge Reset_7Seg_n) begin
    if (!Reset_7Seg_n) begin
      bin              <= '0;
      bcd              <= '0;
      bit_cnt          <= '0;
      ovf_latch        <= 1'b0;
      Bcd_Busy         <= 1'b0;
      Bcd_Digits_Valid <= 1'b0;
      Bcd_Overflow     <= 1'b0;
      {Bcd_Digit_5, Bcd_Digit_4, Bcd_Digit_3,
       Bcd_Digit_2, Bcd_Digit_1, Bcd_Digit_0} <= '0;
`ifdef ELITE_BCD_LEADING_BLANK_EN
      mask_q <= 6'b111110;
`endif
    end else begin
      Bcd_Digits_Valid <= 1'b0;
      case (state)
        S_IDLE: if (pend) begin
          bin       <= (pend_word > MAX_W) ? MAX_W : pend_word;
          ovf_latch <= (pend_word > MAX_W);
          bcd       <= '0;
          bit_cnt   <= '0;
          Bcd_Busy  <= 1'b1;
        end
        S_CONV: begin
          bcd     <= shifted[51:24];
          bin     <= shifted[23:0];
          bit_cnt <= bit_cnt + 5'd1;
        end
        S_DONE: begin
          {Bcd_Digit_5, Bcd_Digit_4, Bcd_Digit_3,
           Bcd_Digit_2, Bcd_Digit_1, Bcd_Digit_0} <= bcd[23:0];
          Bcd_Overflow     <= ovf_latch;
          Bcd_Digits_Valid <= 1'b1;
          Bcd_Busy         <= 1'b0;
`ifdef ELITE_BCD_LEADING_BLANK_EN
          mask_q <= mask_nxt;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_elite_disp_word_bcd.sv
// Bench for elite_disp_word_bcd: frame table plus busy/timeout/reset sequences, queue scoreboard.
module tb_elite_disp_word_bcd;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] word;
  logic       flag;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic       valid, busy, ovf;
  logic [5:0] mask;

  elite_disp_word_bcd #(.TIMEOUT_CYCLES(TO), .MAX_VALUE(999999)) dut (
    .CLOCK_50(clk), .Reset_7Seg_n(rst_n),
    .Elite_7Seg_Disp_Word(word), .Elite_7Seg_Set_Flag(flag),
    .Bcd_Digit_0(d0), .Bcd_Digit_1(d1), .Bcd_Digit_2(d2),
    .Bcd_Digit_3(d3), .Bcd_Digit_4(d4), .Bcd_Digit_5(d5),
    .Bcd_Digits_Valid(valid), .Bcd_Busy(busy),
    .Bcd_Overflow(ovf), .Bcd_Blank_Mask(mask)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    logic        lat_chk;
    int          exp_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  int   nvalid = 0;

  always @(posedge clk) ecnt++;

  function automatic logic [5:0] exp_mask(input logic [23:0] b);
    logic [5:0] m;
    logic       z;
    m = '0;
`ifdef ELITE_BCD_LEADING_BLANK_EN
    z = 1'b1;
    for (int n = 5; n >= 1; n--) begin
      z    = z && (b[4*n +: 4] == 4'd0);
      m[n] = z;
    end
`else
    z = 1'b0;
    m = {5'b0, z};
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      exp_t e;
      nvalid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got digits %0h expected no pulse (edge %0d)",
                 {d5, d4, d3, d2, d1, d0}, ecnt);
      end else begin
        e = sb.pop_front();
        chk("digits", 32'({d5, d4, d3, d2, d1, d0}), 32'(e.bcd));
        chk("overflow", 32'(ovf), 32'(e.ovf));
        chk("blank_mask", 32'(mask), 32'(exp_mask(e.bcd)));
        chk("busy_at_valid", 32'(busy), 32'd0);
        if (e.lat_chk) chk("latency", 32'(ecnt), 32'(e.exp_edge));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int k);
    @(negedge clk);
    word = b;
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    k = ecnt;
  endtask

  task automatic send_frame(input logic [23:0] w, output int k);
    int kk;
    send_byte(w[23:16], kk);
    send_byte(w[15:8], kk);
    send_byte(w[7:0], k);
  endtask

  task automatic push(input logic [23:0] bcd, input logic o, input logic lc, input int e);
    exp_t x;
    x.bcd = bcd; x.ovf = o; x.lat_chk = lc; x.exp_edge = e;
    sb.push_back(x);
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digits"}, 32'({d5, d4, d3, d2, d1, d0}), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overflow"}, 32'(ovf), 32'd0);
`ifdef ELITE_BCD_LEADING_BLANK_EN
    chk({tag, "_mask"}, 32'(mask), 32'h3E);
`else
    chk({tag, "_mask"}, 32'(mask), 32'h00);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   k, n0;

    vt[0] = '{8'h01, 8'hE2, 8'h40, 24'h123456, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 24'h999999, 1'b1};
    vt[2] = '{8'h00, 8'h00, 8'h07, 24'h000007, 1'b0};
    vt[3] = '{8'h0F, 8'h42, 8'h3F, 24'h999999, 1'b0};
    vt[4] = '{8'h0F, 8'h42, 8'h40, 24'h999999, 1'b1};
    vt[5] = '{8'h00, 8'h00, 8'h00, 24'h000000, 1'b0};

    rst_n = 1'b0;
    flag  = 1'b0;
    word  = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_frame({vt[i].b0, vt[i].b1, vt[i].b2}, k);
      push(vt[i].bcd, vt[i].ovf, 1'b1, k + 26);
      @(negedge clk);
      @(negedge clk);
      chk("busy_converting", 32'(busy), 32'd1);
      drain(60);
      @(negedge clk);
    end

    // partial frame abandoned by the gap timeout
    send_byte(8'h00, k);
    send_byte(8'h30, k);
    repeat (TO + 2) @(negedge clk);
    n0 = nvalid;
    send_frame(24'h00002A, k);
    push(24'h000042, 1'b0, 1'b1, k + 26);
    drain(60);
    chk("timeout_pulse_count", 32'(nvalid), 32'(n0 + 1));

    // frames arriving while busy: the middle one is superseded
    n0 = nvalid;
    send_frame(24'd100, k);
    push(24'h000100, 1'b0, 1'b1, k + 26);
    send_frame(24'd200, k);
    chk("busy_during_frames", 32'(busy), 32'd1);
    send_frame(24'd300, k);
    push(24'h000300, 1'b0, 1'b0, 0);
    drain(100);
    repeat (30) @(negedge clk);
    chk("last_wins_pulse_count", 32'(nvalid), 32'(n0 + 2));

    // reset in mid-conversion
    send_frame(24'd999, k);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    n0 = nvalid;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_pulse", 32'(nvalid), 32'(n0));
    send_frame(24'd42, k);
    push(24'h000042, 1'b0, 1'b1, k + 26);
    drain(60);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
